// File: rtl/config_chain_loader.sv
`default_nettype none
// ============================================================================
//  Module   : config_chain_loader
//  Purpose  : Bit-serial loader for the config_cell scan chain. Pulses the
//             chain reset, then streams words in LSB-first through the chain
//             head while watching the tail for bits that failed to clear.
//  Revision : 1.0  initial release
// ============================================================================
module config_chain_loader #(
  parameter int CHAIN_LEN    = 64,
  parameter int WORD_W       = 32,
  parameter int RESET_CYCLES = 2
) (
  input  logic                           config_clk,
  input  logic                           config_reset,
  input  logic                           start,
  input  logic                           abort,
  input  logic [WORD_W-1:0]              s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  output logic                           chain_reset,
  output logic                           chain_data,
  output logic                           chain_shift_en,
  input  logic                           chain_tail,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic [$clog2(CHAIN_LEN+1)-1:0] bits_left
);

  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int NW = $clog2(WORD_W + 1);
  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [BW-1:0] c_CHAIN    = BW'(CHAIN_LEN);
  localparam logic [NW-1:0] c_WORD     = NW'(WORD_W);
  localparam logic [RW-1:0] c_RST_LAST = RW'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST   = 3'd1,
    S_FETCH = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [RW-1:0]       r_rst_cnt;
  logic [WORD_W-1:0]   r_shreg;
  logic [NW-1:0]       r_word_left;
  logic [BW-1:0]       r_bits_left;
  logic                r_error;

  logic                w_ready;
  logic                w_chain_reset;
  logic                w_shift_en;
  logic [NW-1:0]       w_take;

  // Bits taken from a freshly fetched word: a full word, or only what the chain still needs
  assign w_take = (int'(r_bits_left) >= WORD_W) ? c_WORD : NW'(r_bits_left);

  // State register
  always_ff @(posedge config_clk or negedge config_reset) begin
    if (!config_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and per-cycle strobes; abort suppresses every strobe in its own cycle
  always_comb begin
    w_next        = r_state;
    w_ready       = 1'b0;
    w_chain_reset = 1'b0;
    w_shift_en    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_RST;
      end
      S_RST: begin
        if (abort) begin
          w_next = S_IDLE;
        end else begin
          w_chain_reset = 1'b1;
          if (r_rst_cnt == c_RST_LAST) w_next = S_FETCH;
        end
      end
      S_FETCH: begin
        if (abort) begin
          w_next = S_IDLE;
        end else begin
          w_ready = 1'b1;
          if (s_valid) w_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          w_next = S_IDLE;
        end else begin
          w_shift_en = 1'b1;
          if (r_word_left == NW'(1)) begin
            w_next = (r_bits_left == BW'(1)) ? S_DONE : S_FETCH;
          end
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath: reset timer, shift register, word/chain bit counters and sticky tail error
  always_ff @(posedge config_clk or negedge config_reset) begin
    if (!config_reset) begin
      r_rst_cnt   <= '0;
      r_shreg     <= '0;
      r_word_left <= '0;
      r_bits_left <= '0;
      r_error     <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_error     <= 1'b0;
        r_bits_left <= c_CHAIN;
        r_rst_cnt   <= '0;
      end
      if (w_chain_reset) begin
        r_rst_cnt <= r_rst_cnt + RW'(1);
      end
      if (w_ready && s_valid) begin
        r_shreg     <= s_data;
        r_word_left <= w_take;
      end
      if (w_shift_en) begin
        r_shreg     <= r_shreg >> 1;
        r_word_left <= r_word_left - NW'(1);
        r_bits_left <= r_bits_left - BW'(1);
        // The tail must still hold reset zeros while the first load is pushed through
        if (chain_tail) r_error <= 1'b1;
      end
    end
  end

  assign s_ready        = w_ready;
  assign chain_reset    = w_chain_reset;
  assign chain_shift_en = w_shift_en;
  assign chain_data     = w_shift_en & r_shreg[0];
  assign busy           = (r_state != S_IDLE);
  assign done           = (r_state == S_DONE);
  assign error          = r_error;
  assign bits_left      = r_bits_left;

endmodule
`default_nettype wire

// File: tb/tb_config_chain_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_config_chain_loader
//  Purpose  : Self-checking bench for config_chain_loader (40/16/2 instance
//             plus a 32/32 single-word instance).
//  Revision : 1.0  initial release
// ============================================================================
module tb_config_chain_loader;

  logic        clk;
  logic        config_reset;
  logic        start, abort, s_valid, chain_tail;
  logic [15:0] s_data;
  logic        s_ready, chain_reset, chain_data, chain_shift_en, busy, done, error;
  logic [5:0]  bits_left;

  logic        start2, s_valid2;
  logic [31:0] s_data2;
  logic        s_ready2, chain_reset2, chain_data2, chain_shift_en2, busy2, done2, error2;
  logic [5:0]  bits_left2;

  int checks = 0;
  int errors = 0;

  config_chain_loader #(.CHAIN_LEN(40), .WORD_W(16), .RESET_CYCLES(2)) u_dut (
    .config_clk(clk), .config_reset(config_reset), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .chain_reset(chain_reset),
    .chain_data(chain_data), .chain_shift_en(chain_shift_en), .chain_tail(chain_tail),
    .busy(busy), .done(done), .error(error), .bits_left(bits_left)
  );

  config_chain_loader #(.CHAIN_LEN(32), .WORD_W(32), .RESET_CYCLES(2)) u_dut32 (
    .config_clk(clk), .config_reset(config_reset), .start(start2), .abort(1'b0),
    .s_data(s_data2), .s_valid(s_valid2), .s_ready(s_ready2), .chain_reset(chain_reset2),
    .chain_data(chain_data2), .chain_shift_en(chain_shift_en2), .chain_tail(1'b0),
    .busy(busy2), .done(done2), .error(error2), .bits_left(bits_left2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] w0, w1, w2;
    int          stall_word;   // word index whose FETCH sees s_valid withheld
    int          stall;        // number of withheld FETCH cycles
    int          tail_at;      // shift index where chain_tail is forced 1 (-1 none)
    logic [39:0] exp_stream;   // bit i = chain_data on shift cycle i
    int          exp_done;     // cycle of done (cycle 1 = first cycle after start edge)
    int          exp_err_cyc;  // first cycle error reads 1 (0 = never)
    logic        exp_err;      // error after the load
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc = 1, bit_idx = 0, widx = 0, stall_left, n_rst = 0, n_shift = 0;
    int done_cyc = 0, err_cyc = 0;
    stall_left = v.stall;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk($sformatf("v%0d_bits_left_at_start", idx), bits_left, 40);
    chk($sformatf("v%0d_error_cleared", idx), error, 0);
    while (cyc <= 200 && done_cyc == 0) begin
      if (chain_reset) n_rst++;
      if (error && err_cyc == 0) err_cyc = cyc;
      if (done) begin
        done_cyc = cyc;
        chk($sformatf("v%0d_bits_left_at_done", idx), bits_left, 0);
      end
      case (widx)
        0: s_data = v.w0;
        1: s_data = v.w1;
        default: s_data = v.w2;
      endcase
      s_valid = (widx < 3) && !(widx == v.stall_word && stall_left > 0);
      if (chain_shift_en) begin
        if (bit_idx < 40)
          chk($sformatf("v%0d_data_bit%0d", idx, bit_idx), chain_data, v.exp_stream[bit_idx]);
        else
          chk($sformatf("v%0d_extra_shift", idx), bit_idx, 39);
        chain_tail = (bit_idx == v.tail_at);
        bit_idx++;
        n_shift++;
      end else begin
        chain_tail = 1'b0;
      end
      if (s_ready && s_valid) widx++;
      else if (s_ready && widx == v.stall_word && stall_left > 0) stall_left--;
      tick();
      cyc++;
    end
    s_valid = 1'b0;
    chain_tail = 1'b0;
    chk($sformatf("v%0d_done_cycle", idx), done_cyc, v.exp_done);
    chk($sformatf("v%0d_shift_cycles", idx), n_shift, 40);
    chk($sformatf("v%0d_reset_cycles", idx), n_rst, 2);
    chk($sformatf("v%0d_error_cycle", idx), err_cyc, v.exp_err_cyc);
    chk($sformatf("v%0d_error_after_done", idx), error, v.exp_err);
    chk($sformatf("v%0d_idle_after_done", idx), {busy, done}, 2'b00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{16'hA5A5, 16'h0F0F, 16'h00C3, 1, 0, -1, 40'hC3_0F0F_A5A5, 46, 0, 1'b0};
    vecs[1] = '{16'hA5A5, 16'h0F0F, 16'h00C3, 1, 5, -1, 40'hC3_0F0F_A5A5, 51, 0, 1'b0};
    vecs[2] = '{16'hA5A5, 16'h0F0F, 16'h00C3, 1, 0, 16, 40'hC3_0F0F_A5A5, 46, 22, 1'b1};
    vecs[3] = '{16'hFFFF, 16'h0000, 16'hFF5A, 2, 2, -1, 40'h5A_0000_FFFF, 48, 0, 1'b0};
    vecs[4] = '{16'h1234, 16'h8001, 16'hAB80, 0, 1, 39, 40'h80_8001_1234, 47, 47, 1'b1};

    config_reset = 1'b0;
    start = 0; abort = 0; s_valid = 0; chain_tail = 0; s_data = '0;
    start2 = 0; s_valid2 = 0; s_data2 = '0;
    tick();
    tick();
    chk("reset_busy", busy, 0);
    chk("reset_strobes", {s_ready, chain_reset, chain_shift_en, chain_data, done, error}, 0);
    chk("reset_bits_left", bits_left, 0);
    chk("reset_busy32", busy2, 0);
    config_reset = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // Table-driven full loads
    for (int i = 0; i < 5; i++) begin
      run_vec(i, vecs[i]);
      tick();
    end

    // Abort in SHIFT after 20 bits have gone out
    start = 1'b1; tick(); start = 1'b0;
    s_valid = 1'b1; s_data = 16'hA5A5;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      if (chain_shift_en) begin
        if (n == 20) break;
        n++;
      end
      tick();
    end
    chk("abort_reached_20", n, 20);
    abort = 1'b1;
    tick();
    abort = 1'b0; s_valid = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_bits_left", bits_left, 20);
    chk("abort_strobes", {chain_shift_en, chain_reset}, 0);
    tick(); tick(); tick();
    chk("abort_no_late_done", {busy, done}, 0);

    // Abort in FETCH beats a simultaneous valid word
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!s_ready && n < 20) begin tick(); n++; end
    chk("fetch_reached", s_ready, 1);
    s_valid = 1'b1; s_data = 16'hFFFF; abort = 1'b1;
    tick();
    abort = 1'b0; s_valid = 1'b0;
    chk("fetch_abort_busy", busy, 0);
    chk("fetch_abort_bits_left", bits_left, 40);
    tick();

    // Async reset in the middle of SHIFT, with a stale 1 on the tail
    start = 1'b1; tick(); start = 1'b0;
    s_valid = 1'b1; s_data = 16'h5555;
    n = 0;
    for (int c = 0; c < 100 && n < 10; c++) begin
      chain_tail = chain_shift_en;
      if (chain_shift_en) n++;
      tick();
    end
    chk("midreset_in_shift", chain_shift_en, 1);
    chk("midreset_err_before", error, 1);
    #2;
    config_reset = 1'b0;
    #1;
    chk("midreset_flags", {busy, s_ready, chain_reset, chain_shift_en, chain_data, done, error}, 0);
    chk("midreset_bits_left", bits_left, 0);
    @(posedge clk); #1;
    config_reset = 1'b1; chain_tail = 1'b0; s_valid = 1'b0;
    tick();
    run_vec(5, vecs[0]);

    // Single-word 32-bit chain, start pulsed again while busy
    begin
      int cyc = 1, nb = 0, dc = 0;
      logic [31:0] exp32;
      bit taken = 0;
      exp32 = 32'hDEADBEEF;
      start2 = 1'b1; tick(); start2 = 1'b0;
      chk("w32_bits_left_start", bits_left2, 32);
      while (cyc <= 100 && dc == 0) begin
        if (done2) dc = cyc;
        start2 = (cyc == 10);
        s_data2 = exp32;
        s_valid2 = !taken;
        if (chain_shift_en2) begin
          if (nb < 32) chk($sformatf("w32_bit%0d", nb), chain_data2, exp32[nb]);
          nb++;
        end
        if (s_ready2 && s_valid2) taken = 1;
        tick();
        cyc++;
      end
      start2 = 1'b0; s_valid2 = 1'b0;
      chk("w32_shift_cycles", nb, 32);
      chk("w32_done_cycle", dc, 36);
      chk("w32_idle_after", busy2, 0);
      tick(); tick(); tick();
      chk("w32_start_ignored", {busy2, chain_reset2}, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
